// File: rtl/sys_mem_ctrl.sv
`timescale 1ns/1ps
// sys_mem_ctrl
//   System memory subsystem that sits behind memInerf. Holds a byte-addressed
//   memory and services one read or write request at a time with a fixed
//   latency. A write stores a 16-bit little-endian halfword at a and a+1,
//   and the second byte wraps at the top of memory. A read returns the byte
//   at a. After each response the controller waits for both request lines
//   to drop, so a held request is serviced only once.
//
// Ports
//   clk          system clock
//   reset_n      active-low reset, asserted asynchronously
//   read_req     read request
//   write_req    write request (wins when both are high)
//   addrin       byte address, latched at acceptance
//   datain       16-bit write data, latched at acceptance
//   dataout      last byte read; holds until the next read completes
//   mem_resp     one-cycle completion pulse
//   busy         high in every state except IDLE
//   protocol_err sticky; set when both requests were high at acceptance
module sys_mem_ctrl #(
  parameter int ADDR_W  = 14,
  parameter int DEPTH   = 16384,  // must equal 2**ADDR_W
  parameter int LATENCY = 3       // 1..15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [ADDR_W-1:0] addrin,
  input  logic [15:0]       datain,
  output logic [7:0]        dataout,
  output logic              mem_resp,
  output logic              busy,
  output logic              protocol_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam int HALF = DEPTH / 2;

  logic [1:0]        state_reg;
  logic [3:0]        cnt_reg;
  logic              op_wr_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       data_reg;
  logic              mem_resp_reg;
  logic              busy_reg;
  logic              perr_reg;
  logic              rd_valid_reg;
  logic              rd_sel_reg;

  // The memory is split into even and odd byte banks. A halfword write at a
  // and a+1 always touches one byte in each bank, so each bank needs only
  // one write port per cycle.
  logic [7:0] mem_even [HALF];
  logic [7:0] mem_odd  [HALF];
  logic [7:0] rd_even_reg;
  logic [7:0] rd_odd_reg;

  logic              commit;
  logic [ADDR_W-2:0] addr_hi;
  logic [ADDR_W-2:0] even_waddr;
  logic [7:0]        even_wdata;
  logic [7:0]        odd_wdata;

  assign commit  = (state_reg == ST_BUSY) && (cnt_reg == 4'd0);
  assign addr_hi = addr_reg[ADDR_W-1:1];

  // For an odd a, the high byte lands at a+1. That byte is in the even bank
  // at index addr_hi+1. The index wraps to 0 when a is the top address.
  assign even_waddr = addr_hi + {{(ADDR_W-2){1'b0}}, addr_reg[0]};
  assign even_wdata = addr_reg[0] ? data_reg[15:8] : data_reg[7:0];
  assign odd_wdata  = addr_reg[0] ? data_reg[7:0]  : data_reg[15:8];

  // Memory is never reset. While reset is asserted the FSM sits in IDLE,
  // so a write that was in flight is never committed.
  always_ff @(posedge clk) begin
    if (commit) begin
      if (op_wr_reg) begin
        mem_even[even_waddr] <= even_wdata;
        mem_odd[addr_hi]     <= odd_wdata;
      end else begin
        rd_even_reg <= mem_even[addr_hi];
        rd_odd_reg  <= mem_odd[addr_hi];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      op_wr_reg    <= 1'b0;
      addr_reg     <= '0;
      data_reg     <= 16'h0000;
      mem_resp_reg <= 1'b0;
      busy_reg     <= 1'b0;
      perr_reg     <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_sel_reg   <= 1'b0;
    end else begin
      mem_resp_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (read_req || write_req) begin
            state_reg <= ST_BUSY;
            busy_reg  <= 1'b1;
            op_wr_reg <= write_req;
            addr_reg  <= addrin;
            data_reg  <= datain;
            cnt_reg   <= 4'(LATENCY - 1);
            if (read_req && write_req) begin
              perr_reg <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (cnt_reg == 4'd0) begin
            state_reg    <= ST_RESP;
            mem_resp_reg <= 1'b1;
            if (!op_wr_reg) begin
              rd_valid_reg <= 1'b1;
              rd_sel_reg   <= addr_reg[0];
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        ST_RESP: begin
          state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!read_req && !write_req) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // The bank read registers have no reset. rd_valid_reg forces the output
  // to zero after reset until the first read completes. After that the
  // output holds because the bank registers load only on a read commit.
  assign dataout      = rd_valid_reg ? (rd_sel_reg ? rd_odd_reg : rd_even_reg) : 8'h00;
  assign mem_resp     = mem_resp_reg;
  assign busy         = busy_reg;
  assign protocol_err = perr_reg;

endmodule

// File: tb/tb_sys_mem_ctrl.sv
`timescale 1ns/1ps
module tb_sys_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        read_req;
  logic        write_req;
  logic [13:0] addrin;
  logic [15:0] datain;
  logic [7:0]  dataout;
  logic        mem_resp;
  logic        busy;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sys_mem_ctrl #(.ADDR_W(14), .DEPTH(16384), .LATENCY(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .read_req     (read_req),
    .write_req    (write_req),
    .addrin       (addrin),
    .datain       (datain),
    .dataout      (dataout),
    .mem_resp     (mem_resp),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  // Drives one request at 1 ns after a rising edge. The next rising edge is
  // acceptance edge 0. The request stays high until the response edge + 1
  // and for at least 'hold' edges. lat is the first edge where mem_resp is
  // seen high. pulses counts every cycle with mem_resp high.
  task automatic run_req(input logic rd, input logic wr, input logic [13:0] a,
                         input logic [15:0] d, input int hold,
                         output int lat, output int pulses,
                         output logic [7:0] dout_resp, output logic [7:0] dout_before,
                         output logic timed_out);
    logic [7:0] last_dout;
    lat = 0; pulses = 0; dout_resp = 8'h00; dout_before = 8'h00; timed_out = 1'b1;
    last_dout = dataout;
    read_req = rd; write_req = wr; addrin = a; datain = d;
    @(posedge clk); #1;
    addrin = ~a; datain = ~d;  // later input changes must be ignored
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (mem_resp) begin
        pulses++;
        if (lat == 0) begin
          lat = k; dout_resp = dataout; dout_before = last_dout;
        end
      end
      last_dout = dataout;
      if (read_req || write_req) begin
        if (lat != 0 && k >= lat + 1 && k >= hold) begin
          read_req = 1'b0; write_req = 1'b0;
        end
      end else if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    read_req = 1'b0; write_req = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_resp !== 1'b0) begin errors++; $display("FAIL reset_mem_resp: got %b want 0", mem_resp); end
    checks++; if (dataout !== 8'h00) begin errors++; $display("FAIL reset_dataout: got %h want 00", dataout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", protocol_err); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    $display("reset: released, outputs idle");
  endtask

  task automatic test_write_basic;
    int lat, pulses; logic [7:0] dr, db; logic to;
    run_req(1'b0, 1'b1, 14'h0010, 16'hBEEF, 0, lat, pulses, dr, db, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL write_timeout: busy never dropped"); end
    checks++; if (lat != 3) begin errors++; $display("FAIL write_latency: got %0d want 3", lat); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL write_pulses: got %0d want 1", pulses); end
    checks++; if (dr !== 8'h00) begin errors++; $display("FAIL write_dataout_kept: got %h want 00", dr); end
    $display("write 0010 <= BEEF: lat=%0d pulses=%0d", lat, pulses);
  endtask

  task automatic test_read;
    int lat, pulses; logic [7:0] dr, db; logic to;
    run_req(1'b1, 1'b0, 14'h0010, 16'h0000, 0, lat, pulses, dr, db, to);
    checks++; if (to !== 1'b0 || lat != 3 || pulses != 1) begin errors++; $display("FAIL read10_timing: lat=%0d pulses=%0d to=%b want 3/1/0", lat, pulses, to); end
    checks++; if (dr !== 8'hEF) begin errors++; $display("FAIL read10_data: got %h want EF", dr); end
    $display("read 0010 -> %h", dr);
    run_req(1'b1, 1'b0, 14'h0011, 16'h0000, 0, lat, pulses, dr, db, to);
    checks++; if (to !== 1'b0 || lat != 3 || pulses != 1) begin errors++; $display("FAIL read11_timing: lat=%0d pulses=%0d to=%b want 3/1/0", lat, pulses, to); end
    checks++; if (db !== 8'hEF) begin errors++; $display("FAIL read11_before_resp: got %h want EF", db); end
    checks++; if (dr !== 8'hBE) begin errors++; $display("FAIL read11_data: got %h want BE", dr); end
    $display("read 0011 -> %h (previous %h)", dr, db);
  endtask

  task automatic test_wrap;
    int lat, pulses; logic [7:0] dr, db; logic to;
    run_req(1'b0, 1'b1, 14'h3FFF, 16'h1234, 0, lat, pulses, dr, db, to);
    checks++; if (to !== 1'b0 || lat != 3) begin errors++; $display("FAIL wrap_write: lat=%0d to=%b want 3/0", lat, to); end
    $display("write 3FFF <= 1234");
    run_req(1'b1, 1'b0, 14'h3FFF, 16'h0000, 0, lat, pulses, dr, db, to);
    checks++; if (dr !== 8'h34) begin errors++; $display("FAIL wrap_read3fff: got %h want 34", dr); end
    $display("read 3FFF -> %h", dr);
    run_req(1'b1, 1'b0, 14'h0000, 16'h0000, 0, lat, pulses, dr, db, to);
    checks++; if (dr !== 8'h12) begin errors++; $display("FAIL wrap_read0000: got %h want 12", dr); end
    $display("read 0000 -> %h", dr);
  endtask

  task automatic test_back_to_back;
    int lat, pulses; logic [7:0] dr, db; logic to;
    run_req(1'b1, 1'b0, 14'h0010, 16'h0000, 12, lat, pulses, dr, db, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL hold_timeout: busy never dropped"); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
    checks++; if (dr !== 8'hEF) begin errors++; $display("FAIL hold_data: got %h want EF", dr); end
    $display("held read 0010 for 12 cycles: pulses=%0d data=%h", pulses, dr);
    run_req(1'b1, 1'b0, 14'h0011, 16'h0000, 0, lat, pulses, dr, db, to);
    checks++; if (lat != 3 || pulses != 1) begin errors++; $display("FAIL next_accept: lat=%0d pulses=%0d want 3/1", lat, pulses); end
    checks++; if (dr !== 8'hBE) begin errors++; $display("FAIL next_data: got %h want BE", dr); end
    $display("next read 0011 -> %h", dr);
  endtask

  task automatic test_protocol_err;
    int lat, pulses; logic [7:0] dr, db; logic to;
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL perr_initial: got %b want 0", protocol_err); end
    run_req(1'b1, 1'b1, 14'h0020, 16'hA55A, 0, lat, pulses, dr, db, to);
    checks++; if (lat != 3 || pulses != 1) begin errors++; $display("FAIL perr_timing: lat=%0d pulses=%0d want 3/1", lat, pulses); end
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_set: got %b want 1", protocol_err); end
    checks++; if (dr !== 8'hBE) begin errors++; $display("FAIL perr_is_write: dataout %h want BE", dr); end
    $display("read+write 0020 <= A55A: protocol_err=%b", protocol_err);
    run_req(1'b1, 1'b0, 14'h0020, 16'h0000, 0, lat, pulses, dr, db, to);
    checks++; if (dr !== 8'h5A) begin errors++; $display("FAIL perr_read20: got %h want 5A", dr); end
    run_req(1'b1, 1'b0, 14'h0021, 16'h0000, 0, lat, pulses, dr, db, to);
    checks++; if (dr !== 8'hA5) begin errors++; $display("FAIL perr_read21: got %h want A5", dr); end
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b want 1", protocol_err); end
    $display("read 0020/0021 -> 5A/%h, protocol_err=%b", dr, protocol_err);
  endtask

  task automatic test_reset_mid_op;
    int lat, pulses, stray; logic [7:0] dr, db; logic to;
    run_req(1'b0, 1'b1, 14'h0040, 16'h1111, 0, lat, pulses, dr, db, to);
    write_req = 1'b1; addrin = 14'h0040; datain = 16'hCAFE;
    @(posedge clk); #1;  // accepted, counter = 2
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    @(posedge clk); #1;  // counter = 1
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL midrst_perr: got %b want 0", protocol_err); end
    write_req = 1'b0;
    stray = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (mem_resp) stray++;
    end
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (mem_resp) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL midrst_no_resp: %0d pulses want 0", stray); end
    run_req(1'b1, 1'b0, 14'h0040, 16'h0000, 0, lat, pulses, dr, db, to);
    checks++; if (db !== 8'h00) begin errors++; $display("FAIL midrst_dout_reset: got %h want 00", db); end
    checks++; if (dr !== 8'h11) begin errors++; $display("FAIL midrst_mem40: got %h want 11", dr); end
    run_req(1'b1, 1'b0, 14'h0041, 16'h0000, 0, lat, pulses, dr, db, to);
    checks++; if (dr !== 8'h11) begin errors++; $display("FAIL midrst_mem41: got %h want 11", dr); end
    $display("reset during write 0040 <= CAFE: memory kept %h", dr);
    run_req(1'b0, 1'b1, 14'h0040, 16'hCAFE, 0, lat, pulses, dr, db, to);
    checks++; if (lat != 3 || pulses != 1) begin errors++; $display("FAIL postrst_write: lat=%0d pulses=%0d want 3/1", lat, pulses); end
    run_req(1'b1, 1'b0, 14'h0040, 16'h0000, 0, lat, pulses, dr, db, to);
    checks++; if (dr !== 8'hFE) begin errors++; $display("FAIL postrst_read40: got %h want FE", dr); end
    run_req(1'b1, 1'b0, 14'h0041, 16'h0000, 0, lat, pulses, dr, db, to);
    checks++; if (dr !== 8'hCA) begin errors++; $display("FAIL postrst_read41: got %h want CA", dr); end
    $display("write 0040 <= CAFE after reset: read back FE/%h", dr);
  endtask

  initial begin
    reset_n = 1'b0; read_req = 1'b0; write_req = 1'b0;
    addrin = 14'h0000; datain = 16'h0000;
    test_reset();
    test_write_basic();
    test_read();
    test_wrap();
    test_back_to_back();
    test_protocol_err();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
